if_stage: RTL

- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Generates the fetch PC and chip-enable that drive the instruction ROM, and captures the ROM's combinational instruction word.
- Registers the {pc, inst} pair into the IF/ID boundary for the decoder.
- Handles redirects from the branch unit in ID and exception/trap flushes from the control unit.

---
 rtl/if_stage_pkg.sv | 38 +++
 rtl/if_stage_pc_reg.sv | 114 +++++++++++
 rtl/if_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared constants and types for the instruction-fetch stage.
//   - reset / chip-enable encodings, the bubble word and bus widths
//   - pc_src_e: which source the PC register loads on the next edge
//   - is_misaligned(): true when a fetch target is not word aligned
// Optional feature macro used by the importing files: IF_MISALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
package if_stage_pkg;

    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;
    localparam int          INST_ADDR_W   = 32;
    localparam int          INST_W        = 32;
    localparam int          STALL_W       = 6;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;

    // Positions inside the stall vector coming from the control unit.
    localparam int STALL_PC_BIT = 0;
    localparam int STALL_IF_BIT = 1;
    localparam int STALL_ID_BIT = 2;

    typedef enum logic [2:0] {
        PC_SRC_HOLD,
        PC_SRC_RESET,
        PC_SRC_FLUSH,
        PC_SRC_PENDING,
        PC_SRC_BRANCH,
        PC_SRC_SEQ
    } pc_src_e;

    function automatic logic is_misaligned(input logic [INST_ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// ---------------------------------------------------------------------------
// if_stage_pc_reg
// Fetch PC register, pending-branch register and ROM chip-enable.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   hold_pc                  stall bit 0: keep the current PC
//   flush, new_pc            trap/exception redirect (highest priority)
//   branch_flag_i,
//   branch_target_address_i  taken branch resolved in ID
//   pc, ce                   fetch address and chip enable to the ROM
//   pending_valid            a branch captured during a stall is waiting
//   misalign_load            (IF_MISALIGN_CHECK_EN only) this edge loads a
//                            misaligned target
// ---------------------------------------------------------------------------
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = PC_RESET_ADDR,
    parameter logic [INST_ADDR_W-1:0] PC_STEP  = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold_pc,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_address_i,
    output logic [INST_ADDR_W-1:0] pc,
    output logic                   ce,
    output logic                   pending_valid
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic                   misalign_load
`endif
);

    logic [INST_ADDR_W-1:0] pending_target;
    logic [INST_ADDR_W-1:0] pending_target_next;
    logic                   pending_valid_next;
    logic [INST_ADDR_W-1:0] load_target;
    logic [INST_ADDR_W-1:0] pc_next;
    pc_src_e                pc_src;

    // Choose the PC source in priority order. A branch that resolves while
    // the PC is held is parked in the pending register so it is not lost.
    always_comb begin
        pc_src              = PC_SRC_HOLD;
        pending_valid_next  = pending_valid;
        pending_target_next = pending_target;
        if (ce == CHIP_DISABLE) begin
            pc_src = PC_SRC_RESET;
        end else if (flush) begin
            pc_src             = PC_SRC_FLUSH;
            pending_valid_next = 1'b0;
        end else if (hold_pc) begin
            pc_src = PC_SRC_HOLD;
            if (branch_flag_i) begin
                pending_target_next = branch_target_address_i;
                pending_valid_next  = 1'b1;
            end
        end else if (pending_valid) begin
            pc_src             = PC_SRC_PENDING;
            pending_valid_next = 1'b0;
        end else if (branch_flag_i) begin
            pc_src = PC_SRC_BRANCH;
        end else begin
            pc_src = PC_SRC_SEQ;
        end
    end

    // Resolve the selected source into the next PC value.
    always_comb begin
        load_target = ZERO_WORD;
        pc_next     = pc;
        unique case (pc_src)
            PC_SRC_FLUSH:   load_target = new_pc;
            PC_SRC_PENDING: load_target = pending_target;
            PC_SRC_BRANCH:  load_target = branch_target_address_i;
            default:        load_target = ZERO_WORD;
        endcase
        unique case (pc_src)
            PC_SRC_HOLD:  pc_next = pc;
            PC_SRC_RESET: pc_next = RESET_PC;
            PC_SRC_SEQ:   pc_next = pc + PC_STEP;
`ifdef IF_MISALIGN_CHECK_EN
            default:      pc_next = {load_target[INST_ADDR_W-1:2], 2'b00};
`else
            default:      pc_next = load_target;
`endif
        endcase
    end

`ifdef IF_MISALIGN_CHECK_EN
    assign misalign_load = (pc_src inside {PC_SRC_FLUSH, PC_SRC_PENDING, PC_SRC_BRANCH})
                           && is_misaligned(load_target);
`endif

    // State registers; ce rises on the first edge out of reset while the PC
    // is still parked at RESET_PC, so RESET_PC is the first fetched address.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            ce             <= CHIP_DISABLE;
            pc             <= RESET_PC;
            pending_valid  <= 1'b0;
            pending_target <= ZERO_WORD;
        end else begin
            ce             <= CHIP_ENABLE;
            pc             <= pc_next;
            pending_valid  <= pending_valid_next;
            pending_target <= pending_target_next;
        end
    end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: drives the instruction ROM and registers the
// {pc, inst} pair into the IF/ID boundary.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall[5:0]               bit0 hold PC, bit1 hold IF, bit2 hold ID
//   flush, new_pc            trap/exception redirect
//   branch_flag_i,
//   branch_target_address_i  taken branch from ID
//   inst_i                   ROM data for the current pc
//   pc, ce                   ROM address and chip enable
//   id_pc, id_inst           instruction presented to ID (0 = bubble)
//   misalign_o               (IF_MISALIGN_CHECK_EN only) misaligned redirect,
//                            aligned with the bubble it causes in ID
// Optional feature macro: IF_MISALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = PC_RESET_ADDR,
    parameter logic [INST_ADDR_W-1:0] PC_STEP  = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_address_i,
    input  logic [INST_W-1:0]      inst_i,
    output logic [INST_ADDR_W-1:0] pc,
    output logic                   ce,
    output logic [INST_ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0]      id_inst
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic                   misalign_o
`endif
);

    logic pending_valid;
    logic misalign_load;
    logic unused_stall;

    // Stall bits above ID belong to later stages.
    assign unused_stall = ^stall[STALL_W-1:STALL_ID_BIT+1];

    if_stage_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk                     (clk),
        .rst                     (rst),
        .hold_pc                 (stall[STALL_PC_BIT]),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .pc                      (pc),
        .ce                      (ce),
        .pending_valid           (pending_valid)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .misalign_load           (misalign_load)
`endif
    );

`ifndef IF_MISALIGN_CHECK_EN
    assign misalign_load = 1'b0;
`endif

    // IF/ID boundary. A redirect (branch, pending branch or misaligned
    // target) squashes whatever was fetched on the wrong path.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            id_pc   <= ZERO_WORD;
            id_inst <= ZERO_WORD;
        end else if (flush) begin
            id_pc   <= ZERO_WORD;
            id_inst <= ZERO_WORD;
        end else if (stall[STALL_IF_BIT] && !stall[STALL_ID_BIT]) begin
            id_pc   <= ZERO_WORD;
            id_inst <= ZERO_WORD;
        end else if (stall[STALL_IF_BIT] && stall[STALL_ID_BIT]) begin
            id_pc   <= id_pc;
            id_inst <= id_inst;
        end else if (branch_flag_i || pending_valid || misalign_load) begin
            id_pc   <= ZERO_WORD;
            id_inst <= ZERO_WORD;
        end else if (ce == CHIP_DISABLE) begin
            id_pc   <= ZERO_WORD;
            id_inst <= ZERO_WORD;
        end else begin
            id_pc   <= pc;
            id_inst <= inst_i;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    // Raised on the same edge as the bubble so it travels with the ID slot.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= misalign_load;
        end
    end
`endif

endmodule
